// File: rtl/motor_ramp_scheduler_pkg.sv
// Shared constants and sequencer state encoding for motor_ramp_scheduler.
// MAX_DC must agree with the motor_controller instances on the same duty bus.
package motor_ramp_scheduler_pkg;

    localparam int DUTY_CYCLE_SIZE = 10;
    localparam int MAX_DC          = 1000;

    typedef enum logic [1:0] {
        MRS_IDLE  = 2'd0,
        MRS_RAMP  = 2'd1,
        MRS_DRAIN = 2'd2,
        MRS_HOLD  = 2'd3
    } mrs_state_e;

endpackage

// File: rtl/motor_ramp_scheduler_tick.sv
// Ramp prescaler: free-running 0..RAMP_DIV-1 counter, tick_o high on the wrap cycle.
module motor_ramp_scheduler_tick #(
    parameter int RAMP_DIV = 50000
) (
    input  logic clk_i,
    input  logic reset_ni,
    output logic tick_o
);

    localparam int              CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/motor_ramp_scheduler.sv
// Per-motor duty slew and safe direction reversal in front of the motor_controller bank.
// One shared step/clamp datapath is time-multiplexed over the motors after every ramp tick.
module motor_ramp_scheduler
    import motor_ramp_scheduler_pkg::*;
#(
    parameter int NUM_MOTORS = 6,
    parameter int DC_W       = DUTY_CYCLE_SIZE,
    parameter int RAMP_DIV   = 50000,
    parameter int RAMP_STEP  = 4,
    parameter int REV_HOLD   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         estop,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [2:0]                   cmd_motor,
    input  logic                         cmd_dir,
    input  logic                         cmd_on,
    input  logic [DC_W-1:0]              cmd_duty,
    output logic                         cmd_err,
    output logic [NUM_MOTORS-1:0]        dir,
    output logic [NUM_MOTORS-1:0]        on,
    output logic [NUM_MOTORS*DC_W-1:0]   duty_cycle,
    output logic [NUM_MOTORS-1:0]        busy
);

    localparam int                SLOT_W    = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int                HOLD_W    = $clog2(REV_HOLD + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_MOTORS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REV_HOLD - 1);
    localparam logic [3:0]        N_X       = 4'(NUM_MOTORS);
    localparam logic [DC_W:0]     STEP_X    = (DC_W + 1)'(RAMP_STEP);
    localparam logic [DC_W-1:0]   MAX_X     = DC_W'(MAX_DC);

    function automatic logic [DC_W-1:0] clamp_dc(input logic [DC_W:0] v);
        return (v > {1'b0, MAX_X}) ? MAX_X : v[DC_W-1:0];
    endfunction

    function automatic logic [DC_W-1:0] step_toward(input logic [DC_W-1:0] cur,
                                                    input logic [DC_W-1:0] tgt);
        logic [DC_W:0] c, t, d, r;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (t > c) begin
            d = t - c;
            r = c + ((d > STEP_X) ? STEP_X : d);
        end else begin
            d = c - t;
            r = c - ((d > STEP_X) ? STEP_X : d);
        end
        return clamp_dc(r);
    endfunction

    logic                  cmd_ready_q, cmd_err_q, slot_act_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [NUM_MOTORS-1:0] dir_q, on_q, tgt_dir_q, tgt_on_q;
    logic [DC_W-1:0]       duty_q     [NUM_MOTORS];
    logic [DC_W-1:0]       tgt_duty_q [NUM_MOTORS];
    mrs_state_e            state_q    [NUM_MOTORS];
    logic [HOLD_W-1:0]     hold_q     [NUM_MOTORS];

    logic              tick, accept, idx_ok, do_ramp, do_drain;
    logic [SLOT_W-1:0] cmd_idx;
    logic              cur_dir, cur_on, t_dir, t_on, dir_d, on_d;
    logic [DC_W-1:0]   cur_duty, t_duty, duty_d;
    mrs_state_e        cur_st, state_d;
    logic [HOLD_W-1:0] cur_hold, hold_d;

    motor_ramp_scheduler_tick #(.RAMP_DIV(RAMP_DIV)) u_tick (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .tick_o   (tick)
    );

    assign accept  = cmd_valid & cmd_ready_q;
    assign idx_ok  = ({1'b0, cmd_motor} < N_X);
    assign cmd_idx = cmd_motor[SLOT_W-1:0];

    always_comb begin
        cur_dir  = dir_q[slot_q];
        cur_on   = on_q[slot_q];
        cur_duty = duty_q[slot_q];
        cur_st   = state_q[slot_q];
        cur_hold = hold_q[slot_q];
        t_dir    = tgt_dir_q[slot_q];
        t_on     = tgt_on_q[slot_q];
        t_duty   = tgt_duty_q[slot_q];
        dir_d    = cur_dir;
        on_d     = cur_on;
        duty_d   = cur_duty;
        state_d  = cur_st;
        hold_d   = cur_hold;
        do_ramp  = 1'b0;
        do_drain = 1'b0;
        case (cur_st)
            MRS_IDLE, MRS_RAMP: begin
                if (t_dir != cur_dir) begin
                    // A parked motor (off, zero duty) can flip without draining.
                    if (cur_on || cur_duty != '0) begin
                        do_drain = 1'b1;
                    end else begin
                        dir_d   = t_dir;
                        do_ramp = 1'b1;
                    end
                end else begin
                    do_ramp = 1'b1;
                end
            end
            MRS_DRAIN: begin
                if (t_dir == cur_dir) do_ramp = 1'b1;
                else                  do_drain = 1'b1;
            end
            default: begin
                if (t_dir == cur_dir) begin
                    do_ramp = 1'b1;
                end else if (cur_hold == HOLD_LAST) begin
                    dir_d   = t_dir;
                    state_d = t_on ? MRS_RAMP : MRS_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = cur_hold + HOLD_W'(1);
                end
            end
        endcase
        if (do_drain) begin
            duty_d = step_toward(cur_duty, '0);
            if (duty_d == '0) begin
                on_d    = 1'b0;
                hold_d  = '0;
                state_d = MRS_HOLD;
            end else begin
                state_d = MRS_DRAIN;
            end
        end
        if (do_ramp) begin
            // Enable stays up while ramping down to an "off" target, drops on arrival.
            duty_d  = step_toward(cur_duty, t_duty);
            on_d    = t_on | (cur_on & (duty_d != t_duty));
            state_d = (duty_d == t_duty) ? MRS_IDLE : MRS_RAMP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            slot_act_q  <= 1'b0;
            slot_q      <= '0;
            dir_q       <= '0;
            on_q        <= '0;
            tgt_dir_q   <= '0;
            tgt_on_q    <= '0;
            for (int k = 0; k < NUM_MOTORS; k++) begin
                duty_q[k]     <= '0;
                tgt_duty_q[k] <= '0;
                state_q[k]    <= MRS_IDLE;
                hold_q[k]     <= '0;
            end
        end else begin
            cmd_ready_q <= ~estop;
            cmd_err_q   <= accept & ~idx_ok;
            if (tick) begin
                slot_act_q <= 1'b1;
                slot_q     <= '0;
            end else if (slot_act_q) begin
                if (slot_q == LAST_SLOT) slot_act_q <= 1'b0;
                else                     slot_q     <= slot_q + SLOT_W'(1);
            end
            if (estop) begin
                on_q      <= '0;
                tgt_on_q  <= '0;
                tgt_dir_q <= dir_q;
                for (int k = 0; k < NUM_MOTORS; k++) begin
                    duty_q[k]     <= '0;
                    tgt_duty_q[k] <= '0;
                    state_q[k]    <= MRS_IDLE;
                    hold_q[k]     <= '0;
                end
            end else begin
                if (slot_act_q) begin
                    dir_q[slot_q]   <= dir_d;
                    on_q[slot_q]    <= on_d;
                    duty_q[slot_q]  <= duty_d;
                    state_q[slot_q] <= state_d;
                    hold_q[slot_q]  <= hold_d;
                end
                if (accept && idx_ok) begin
                    tgt_dir_q[cmd_idx]  <= cmd_dir;
                    tgt_on_q[cmd_idx]   <= cmd_on;
                    tgt_duty_q[cmd_idx] <= cmd_on ? clamp_dc({1'b0, cmd_duty}) : '0;
                end
            end
        end
    end

    always_comb begin
        duty_cycle = '0;
        busy       = '0;
        for (int k = 0; k < NUM_MOTORS; k++) begin
            duty_cycle[k*DC_W +: DC_W] = duty_q[k];
            busy[k] = (state_q[k] != MRS_IDLE) | (dir_q[k] != tgt_dir_q[k]) |
                      (on_q[k] != tgt_on_q[k]) | (duty_q[k] != tgt_duty_q[k]);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cmd_err   = cmd_err_q;
    assign dir       = dir_q;
    assign on        = on_q;

endmodule

// File: tb/tb_motor_ramp_scheduler.sv
// Bench for motor_ramp_scheduler: directed reversal/estop/reset scenarios plus random commands,
// all outputs compared every cycle against a per-motor behavioural model.
module tb_motor_ramp_scheduler;

    localparam int N = 6, DCW = 10, DIV = 16, STEP = 4, RH = 8, MAXD = 1000;
    localparam int S_IDLE = 0, S_RAMP = 1, S_DRAIN = 2, S_HOLD = 3;

    logic             clk = 1'b0;
    logic             reset_n, estop, cmd_valid, cmd_dir, cmd_on;
    logic [2:0]       cmd_motor;
    logic [DCW-1:0]   cmd_duty;
    logic             cmd_ready, cmd_err;
    logic [N-1:0]     dir, on, busy;
    logic [N*DCW-1:0] duty_cycle;

    motor_ramp_scheduler #(
        .NUM_MOTORS(N), .DC_W(DCW), .RAMP_DIV(DIV), .RAMP_STEP(STEP), .REV_HOLD(RH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .estop(estop), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_motor(cmd_motor), .cmd_dir(cmd_dir), .cmd_on(cmd_on),
        .cmd_duty(cmd_duty), .cmd_err(cmd_err), .dir(dir), .on(on),
        .duty_cycle(duty_cycle), .busy(busy)
    );

    always #5 clk = ~clk;

    int lv_dir[N], lv_on[N], lv_duty[N], md[N], md_hold[N];
    int tg_dir[N], tg_on[N], tg_duty[N];
    int m_ready, m_err, e_cnt;
    int n_checks = 0, n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            lv_dir[k] = 0; lv_on[k] = 0; lv_duty[k] = 0; md[k] = S_IDLE; md_hold[k] = 0;
            tg_dir[k] = 0; tg_on[k] = 0; tg_duty[k] = 0;
        end
        m_ready = 0; m_err = 0; e_cnt = 0;
    endtask

    // One service slot of motor k, following the reversal rules directly.
    task automatic serve(input int k);
        int diff, stp;
        bit rev;
        rev = (tg_dir[k] != lv_dir[k]);
        if (md[k] == S_HOLD && rev) begin
            md_hold[k]++;
            if (md_hold[k] == RH) begin
                lv_dir[k] = tg_dir[k];
                md[k] = (tg_on[k] != 0) ? S_RAMP : S_IDLE;
            end
        end else if (rev && (lv_on[k] != 0 || lv_duty[k] > 0)) begin
            lv_duty[k] -= (lv_duty[k] < STEP) ? lv_duty[k] : STEP;
            if (lv_duty[k] == 0) begin
                lv_on[k] = 0; md_hold[k] = 0; md[k] = S_HOLD;
            end else begin
                md[k] = S_DRAIN;
            end
        end else begin
            lv_dir[k] = tg_dir[k];
            diff = tg_duty[k] - lv_duty[k];
            stp = (diff > STEP) ? STEP : ((diff < -STEP) ? -STEP : diff);
            lv_duty[k] += stp;
            if (lv_duty[k] == tg_duty[k]) begin
                lv_on[k] = tg_on[k]; md[k] = S_IDLE;
            end else begin
                lv_on[k] = (lv_on[k] != 0 || tg_on[k] != 0) ? 1 : 0; md[k] = S_RAMP;
            end
        end
    endtask

    task automatic model_edge();
        int c, m;
        bit acc;
        c = e_cnt;
        acc = cmd_valid && (m_ready != 0);
        m = int'(cmd_motor);
        m_err = (acc && m >= N) ? 1 : 0;
        if (estop) begin
            for (int k = 0; k < N; k++) begin
                lv_on[k] = 0; lv_duty[k] = 0; md[k] = S_IDLE; md_hold[k] = 0;
                tg_dir[k] = lv_dir[k]; tg_on[k] = 0; tg_duty[k] = 0;
            end
        end else begin
            if (c >= DIV && (c % DIV) < N) serve(c % DIV);
            if (acc && m < N) begin
                tg_dir[m]  = int'(cmd_dir);
                tg_on[m]   = int'(cmd_on);
                tg_duty[m] = cmd_on ? ((int'(cmd_duty) > MAXD) ? MAXD : int'(cmd_duty)) : 0;
            end
        end
        m_ready = estop ? 0 : 1;
        e_cnt++;
    endtask

    always @(posedge clk) if (reset_n) model_edge();

    always @(negedge clk) begin
        logic [N-1:0]     ed, eo, eb;
        logic [N*DCW-1:0] edc;
        if (reset_n && chk_en) begin
            for (int k = 0; k < N; k++) begin
                ed[k] = (lv_dir[k] != 0);
                eo[k] = (lv_on[k] != 0);
                edc[k*DCW +: DCW] = DCW'(lv_duty[k]);
                eb[k] = (md[k] != S_IDLE) || (lv_dir[k] != tg_dir[k]) ||
                        (lv_on[k] != tg_on[k]) || (lv_duty[k] != tg_duty[k]);
            end
            chk("dir", dir, ed);
            chk("on", on, eo);
            chk("duty_cycle", duty_cycle, edc);
            chk("busy", busy, eb);
            chk("cmd_ready", cmd_ready, m_ready);
            chk("cmd_err", cmd_err, m_err);
        end
    end

    task automatic send(input int m, input int d, input int o, input int duty);
        cmd_valid = 1'b1; cmd_motor = 3'(m); cmd_dir = 1'(d); cmd_on = 1'(o);
        cmd_duty = DCW'(duty);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Return at a negedge such that the next edge sits at tick-window position pos.
    task automatic align(input int pos);
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((e_cnt < DIV || (e_cnt % DIV) != pos) && n < 64);
    endtask

    // Return at the negedge right after motor k's service edge.
    task automatic wait_serviced(input int k);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(e_cnt >= DIV + 1 && ((e_cnt - 1) % DIV) == k) && n < 64);
        if (n >= 64) chk("slot_timeout", 1, 0);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy[k] && n < 3000) begin @(negedge clk); n++; end
        chk("settle", busy[k], 0);
    endtask

    function automatic logic [DCW-1:0] duty_of(input int k);
        return duty_cycle[k*DCW +: DCW];
    endfunction

    initial begin
        int exp_seq[3];
        reset_n = 1'b0; estop = 1'b0; cmd_valid = 1'b0; cmd_motor = '0;
        cmd_dir = 1'b0; cmd_on = 1'b0; cmd_duty = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_duty", duty_cycle, 0);
        chk("rst_on", on, 0);
        chk("rst_ready", cmd_ready, 0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("ready_after_release", cmd_ready, 1);

        // Ramp from rest on m2
        align(10);
        send(2, 0, 1, 10);
        exp_seq = '{4, 8, 10};
        for (int i = 0; i < 3; i++) begin
            wait_serviced(2);
            chk("m2_ramp", duty_of(2), exp_seq[i]);
            chk("m2_on", on[2], 1);
        end
        chk("m2_busy_done", busy[2], 0);

        // Reversal on m0: drain, hold, flip, ramp
        send(0, 0, 1, 12);
        wait_idle(0);
        align(10);
        send(0, 1, 1, 8);
        exp_seq = '{8, 4, 0};
        for (int i = 0; i < 3; i++) begin
            wait_serviced(0);
            chk("m0_drain", duty_of(0), exp_seq[i]);
        end
        chk("m0_off_after_drain", on[0], 0);
        for (int i = 0; i < RH; i++) begin
            wait_serviced(0);
            chk("m0_hold_dir", dir[0], (i == RH - 1) ? 1 : 0);
            chk("m0_hold_duty", duty_of(0), 0);
        end
        exp_seq = '{4, 8, 8};
        for (int i = 0; i < 2; i++) begin
            wait_serviced(0);
            chk("m0_ramp_up", duty_of(0), exp_seq[i]);
            chk("m0_on_up", on[0], 1);
        end

        // Invalid index
        align(10);
        send(7, 1, 1, 100);
        chk("err_pulse", cmd_err, 1);
        @(negedge clk);
        chk("err_clear", cmd_err, 0);

        // Command landing on m4's own slot
        align(4);
        send(4, 0, 1, 20);
        chk("m4_same_slot", duty_of(4), 0);
        wait_serviced(4);
        chk("m4_next_tick", duty_of(4), 4);

        // Clamp and on=0 forcing zero target on m5
        align(10);
        send(5, 0, 1, 1023);
        repeat (3) wait_serviced(5);
        send(5, 0, 0, 500);
        wait_idle(5);
        chk("m5_off", on[5], 0);

        // Estop mid-ramp
        align(10);
        send(1, 0, 1, 200);
        send(3, 1, 1, 300);
        wait_serviced(3);
        wait_serviced(3);
        estop = 1'b1;
        @(negedge clk);
        chk("estop_on", on, 0);
        chk("estop_duty", duty_cycle, 0);
        chk("estop_ready", cmd_ready, 0);
        chk("estop_busy", busy, 0);
        chk("estop_dir3", dir[3], 1);
        repeat (3) @(negedge clk);
        estop = 1'b0;
        align(10);
        send(1, 0, 1, 8);
        wait_serviced(1);
        chk("post_estop_ramp", duty_of(1), 4);

        // Async reset while m0 is holding off before a flip
        send(0, 1, 1, 8);
        wait_idle(0);
        align(10);
        send(0, 0, 1, 4);
        repeat (3) wait_serviced(0);
        chk("hold_dir", dir[0], 1);
        chk("hold_on", on[0], 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_dir", dir, 0);
        chk("arst_on", on, 0);
        chk("arst_duty", duty_cycle, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_back", cmd_ready, 1);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_motor = 3'($urandom_range(0, 7));
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_on    = ($urandom_range(0, 4) != 0);
            cmd_duty  = ($urandom_range(0, 7) == 0) ? DCW'($urandom_range(0, 1023))
                                                    : DCW'($urandom_range(0, 47));
            estop     = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        estop = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_err);
        $fatal(1);
    end

endmodule
